// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C encodings for the slave FSM and bus-condition logic
package i2c_pkg;
  localparam int I2C_BYTE_W = 8;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: synchronises SCL/SDA and derives edge, START and STOP pulses
module i2c_bus_cond (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_sync, sda_sync;
  logic scl_q, sda_q;
  // two-flop synchronisers plus one delayed copy for edge detection; idle bus reads high
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q <= scl_sync[1];
      sda_q <= sda_sync[1];
    end
  assign sda_s = sda_sync[1];
  assign scl_rise = scl_sync[1] & ~scl_q;
  assign scl_fall = ~scl_sync[1] & scl_q;
  assign start = scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
  assign stop = scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
endmodule

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: I2C slave exposing a pointer-addressed bank of 8-bit registers
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h55,
  parameter int NUM_REGS = 4,
  parameter int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [8*NUM_REGS-1:0] reg_o,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  busy
);
  state_t state, state_n;
  logic sda_s, scl_rise, scl_fall, start, stop;
  logic [3:0] bit_cnt;
  logic [I2C_BYTE_W-1:0] shift, shift_n, tx;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [NUM_REGS-1:0][I2C_BYTE_W-1:0] regs;
  logic rx_en, tx_shift, tx_load, ptr_load, ptr_inc, wr_en, cnt_clr, sda_oe;
  logic byte_full, last_bit, addr_hit;

  i2c_bus_cond u_bus (
    .clk(clk),
    .reset(reset),
    .scl(SCL),
    .sda(SDA),
    .sda_s(sda_s),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start(start),
    .stop(stop)
  );

  assign shift_n = {shift[I2C_BYTE_W-2:0], sda_s};
  assign byte_full = bit_cnt == 4'(I2C_BYTE_W);
  assign last_bit = bit_cnt == 4'(I2C_BYTE_W - 1);
  assign addr_hit = shift[7:1] == SLV_ADDR;
  assign ptr_nxt = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign sda_oe = (state inside {ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK}) || (state == ST_RD_DATA && !tx[7]);
  assign SDA = (sda_oe && reset) ? 1'b0 : 1'bz;
  assign busy = !(state inside {ST_IDLE, ST_IGNORE});
  assign reg_o = regs;

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_n;

  // next state and datapath strobes; START/STOP override any SCL edge handling
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    rx_en = 1'b0;
    tx_shift = 1'b0;
    tx_load = 1'b0;
    ptr_load = 1'b0;
    ptr_inc = 1'b0;
    wr_en = 1'b0;
    if (start) begin
      state_n = ST_ADDR;
      cnt_clr = 1'b1;
    end else if (stop) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          rx_en = scl_rise && !byte_full;
          ptr_load = rx_en && last_bit && state == ST_PTR;
          wr_en = rx_en && last_bit && state == ST_WR_DATA;
          if (scl_fall && byte_full)
            state_n = (state == ST_ADDR) ? (addr_hit ? ST_ADDR_ACK : ST_IGNORE) :
                      (state == ST_PTR) ? ST_PTR_ACK : ST_WR_ACK;
        end
        ST_ADDR_ACK: if (scl_fall) begin
          state_n = shift[0] ? ST_RD_DATA : ST_PTR;
          tx_load = shift[0];
          cnt_clr = 1'b1;
        end
        ST_PTR_ACK: if (scl_fall) begin
          state_n = ST_WR_DATA;
          cnt_clr = 1'b1;
        end
        ST_WR_ACK: if (scl_fall) begin
          state_n = ST_WR_DATA;
          cnt_clr = 1'b1;
          ptr_inc = 1'b1;
        end
        ST_RD_DATA: if (scl_fall) begin
          tx_shift = 1'b1;
          state_n = last_bit ? ST_RD_ACK : ST_RD_DATA;
        end
        ST_RD_ACK: begin
          ptr_inc = scl_rise;
          if (scl_rise && sda_s == NACK) state_n = ST_IGNORE;
          else if (scl_fall) begin
            state_n = ST_RD_DATA;
            tx_load = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // bit counter, shifters, pointer and register bank; tx is snapshotted at byte boundaries
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bit_cnt <= '0;
      shift <= '0;
      tx <= '0;
      ptr <= '0;
      regs <= {NUM_REGS{RST_VAL}};
      wr_stb <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_stb <= wr_en;
      if (cnt_clr) bit_cnt <= '0;
      else if (rx_en || tx_shift) bit_cnt <= bit_cnt + 4'd1;
      if (rx_en) shift <= shift_n;
      if (tx_load) tx <= regs[ptr];
      else if (tx_shift) tx <= {tx[I2C_BYTE_W-2:0], 1'b0};
      if (ptr_load) ptr <= PTR_W'(shift_n % NUM_REGS);
      else if (ptr_inc) ptr <= ptr_nxt;
      if (wr_en) begin
        regs[ptr] <= shift_n;
        wr_idx <= ptr;
      end
    end
endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb_i2c_slave_regbank: master BFM on an open-drain bus with scoreboarded responses and writes
module tb_i2c_slave_regbank;
  typedef struct {string name; logic [7:0] val;} rsp_t;
  typedef struct {int idx; logic [7:0] data;} wr_t;

  logic clk = 1'b0, reset = 1'b0, scl = 1'b1, m_oe = 1'b0, watch = 1'b0;
  wire sda;
  logic [31:0] reg_o;
  logic wr_stb, busy;
  logic [1:0] wr_idx;
  int checks = 0, failures = 0, bad_drive = 0;
  rsp_t exp_q[$], act_q[$];
  wr_t exp_wr[$];
  rsp_t ra, re;
  wr_t we;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_slave_regbank dut (
    .clk(clk),
    .reset(reset),
    .SCL(scl),
    .SDA(sda),
    .reg_o(reg_o),
    .wr_stb(wr_stb),
    .wr_idx(wr_idx),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic q();
    repeat (25) @(negedge clk);
  endtask

  task automatic wbit(input logic b);
    m_oe = !b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic rbit(output logic b);
    m_oe = 1'b0; q(); scl = 1'b1; q(); b = sda; q(); scl = 1'b0; q();
  endtask

  task automatic start_c();
    m_oe = 1'b0; q(); scl = 1'b1; q(); m_oe = 1'b1; q(); scl = 1'b0; q();
  endtask

  task automatic stop_c();
    m_oe = 1'b1; q(); scl = 1'b1; q(); m_oe = 1'b0; q();
  endtask

  task automatic send(input string name, input logic [7:0] b, input logic exp_ack);
    logic a;
    exp_q.push_back('{name, {7'd0, exp_ack}});
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
    act_q.push_back('{name, {7'd0, a}});
  endtask

  task automatic recv(input string name, input logic ack, input logic [7:0] exp);
    logic [7:0] d;
    logic b;
    d = '0;
    exp_q.push_back('{name, exp});
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(ack);
    act_q.push_back('{name, d});
  endtask

  task automatic exp_write(input int idx, input logic [7:0] data);
    exp_wr.push_back('{idx, data});
  endtask

  // response scoreboard: pairs each observed ACK/data byte with its expectation
  always @(negedge clk)
    while (act_q.size() > 0) begin
      ra = act_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=none", ra.name, ra.val);
      end else begin
        re = exp_q.pop_front();
        chk(re.name, 32'(ra.val), 32'(re.val));
      end
    end

  // write monitor: every wr_stb must match the next expected register write
  always @(negedge clk)
    if (wr_stb) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual_idx=%0d required=no_write", wr_idx);
      end else begin
        we = exp_wr.pop_front();
        chk("wr_idx", 32'(wr_idx), 32'(we.idx));
        chk("wr_data", 32'(reg_o[8*we.idx +: 8]), 32'(we.data));
      end
    end

  // flags any low level on SDA that the master did not cause
  always @(posedge clk) begin
    #1;
    if (watch && !m_oe && sda === 1'b0) bad_drive++;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_regs", reg_o, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_stb", 32'(wr_stb), 32'h0);
    chk("rst_sda", 32'(sda), 32'h1);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    start_c();
    send("t1_addr_ack", 8'hAA, 1'b0);
    send("t1_ptr_ack", 8'h01, 1'b0);
    exp_write(1, 8'hA5);
    send("t1_data_ack", 8'hA5, 1'b0);
    stop_c();
    chk("t1_regs", reg_o, 32'h0000_A500);
    chk("t1_busy_after_stop", 32'(busy), 32'h0);
    start_c();
    send("t2_addr_ack", 8'hAA, 1'b0);
    send("t2_ptr_ack", 8'h03, 1'b0);
    exp_write(3, 8'h11);
    send("t2_d0_ack", 8'h11, 1'b0);
    exp_write(0, 8'h22);
    send("t2_d1_ack", 8'h22, 1'b0);
    stop_c();
    chk("t2_regs_wrap", reg_o, 32'h1100_A522);
    start_c();
    send("t3pre_addr_ack", 8'hAA, 1'b0);
    send("t3pre_ptr_ack", 8'h02, 1'b0);
    exp_write(2, 8'h5C);
    send("t3pre_data_ack", 8'h5C, 1'b0);
    stop_c();
    chk("t3pre_regs", reg_o, 32'h115C_A522);
    start_c();
    send("t3_addr_ack", 8'hAA, 1'b0);
    send("t3_ptr_ack", 8'h02, 1'b0);
    start_c();
    send("t3_raddr_ack", 8'hAB, 1'b0);
    chk("t3_busy_read", 32'(busy), 32'h1);
    recv("t3_rd_reg2", 1'b0, 8'h5C);
    recv("t3_rd_reg3", 1'b1, 8'h11);
    chk("t3_sda_released", 32'(sda), 32'h1);
    chk("t3_busy_after_nack", 32'(busy), 32'h0);
    stop_c();
    chk("t3_regs", reg_o, 32'h115C_A522);
    watch = 1'b1;
    start_c();
    send("t4_addr_nack", 8'hAC, 1'b1);
    chk("t4_busy_ignore", 32'(busy), 32'h0);
    send("t4_data_nack", 8'h33, 1'b1);
    stop_c();
    watch = 1'b0;
    chk("t4_no_sda_drive", 32'(bad_drive), 32'h0);
    chk("t4_regs", reg_o, 32'h115C_A522);
    start_c();
    send("t5_addr_ack", 8'hAA, 1'b0);
    send("t5_ptr_ack", 8'h02, 1'b0);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    stop_c();
    chk("t5_regs_partial", reg_o, 32'h115C_A522);
    start_c();
    send("t5_raddr_ack", 8'hAB, 1'b0);
    recv("t5_rd_ptr_kept", 1'b1, 8'h5C);
    stop_c();
    start_c();
    send("t5b_addr_ack", 8'hAA, 1'b0);
    send("t5b_ptr_ack", 8'h00, 1'b0);
    exp_write(0, 8'h77);
    send("t5b_data_ack", 8'h77, 1'b0);
    stop_c();
    chk("t5b_regs", reg_o, 32'h115C_A577);
    start_c();
    send("t6_addr_ack", 8'hAA, 1'b0);
    send("t6_ptr_ack", 8'h00, 1'b0);
    start_c();
    send("t6_raddr_ack", 8'hAB, 1'b0);
    chk("t6_sda_driven_low", 32'(sda), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_sda_async_release", 32'(sda), 32'h1);
    chk("t6_regs_reset", reg_o, 32'h0);
    chk("t6_busy_reset", 32'(busy), 32'h0);
    scl = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    start_c();
    send("t6b_addr_ack", 8'hAA, 1'b0);
    send("t6b_ptr_ack", 8'h01, 1'b0);
    exp_write(1, 8'h3C);
    send("t6b_data_ack", 8'h3C, 1'b0);
    stop_c();
    chk("t6b_regs", reg_o, 32'h0000_3C00);
    repeat (20) @(negedge clk);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'h0);
    chk("rsp_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
